// File: rtl/branch_predictor_gshare_if.sv
// Fetch-side lookup, resolve-side update and statistics signals of the gshare predictor.
interface branch_predictor_gshare_if;
  logic [1:0]  mode;
  logic [31:0] current_pc;
  logic        lookup_valid;
  logic [31:0] pc_predict;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_is_cond;
  logic        upd_mispredict;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  // Driver side (fetch/execute pipeline or testbench).
  modport master (
    output mode, current_pc, lookup_valid,
    output upd_valid, upd_pc, upd_target, upd_is_cond, upd_mispredict,
    input  pc_predict, pred_taken, stat_lookups, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  mode, current_pc, lookup_valid,
    input  upd_valid, upd_pc, upd_target, upd_is_cond, upd_mispredict,
    output pc_predict, pred_taken, stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Direct-mapped BTB plus a pattern history table of saturating counters, indexed either
// bimodally (pc bits) or gshare-style (pc bits XOR global history). Lookup is combinational,
// updates land on the clock edge and become visible one cycle later.
module branch_predictor_gshare #(
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned HIST_BITS = 5,
  parameter int unsigned CTR_BITS  = 2
) (
  input logic                        clk,
  input logic                        reset,
  branch_predictor_gshare_if.slave   bus
);

  localparam int unsigned Depth   = 1 << IDX_BITS;
  localparam int unsigned TagBits = 30 - IDX_BITS;

  localparam logic [CTR_BITS-1:0] CtrMax    = '1;
  localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  // Table state
  logic                 btb_valid_q  [Depth];
  logic [TagBits-1:0]   btb_tag_q    [Depth];
  logic [31:0]          btb_target_q [Depth];
  logic [CTR_BITS-1:0]  pht_q        [Depth];
  logic [HIST_BITS-1:0] bhsr_q, bhsr_d;
  logic [31:0]          stat_lookups_q, stat_lookups_d;
  logic [31:0]          stat_mispredicts_q, stat_mispredicts_d;

  // Lookup path
  logic [IDX_BITS-1:0]  lkp_idx;
  logic [TagBits-1:0]   lkp_tag;
  logic                 lkp_hit;
  logic [IDX_BITS-1:0]  lkp_pht_idx;
  logic [CTR_BITS-1:0]  lkp_ctr;
  logic                 lkp_taken;

  // Update path
  logic [IDX_BITS-1:0]  upd_idx;
  logic [TagBits-1:0]   upd_tag;
  logic                 upd_hit;
  logic [IDX_BITS-1:0]  upd_pht_idx;
  logic [CTR_BITS-1:0]  upd_ctr;
  logic [CTR_BITS-1:0]  upd_ctr_next;
  logic                 actual_taken;
  logic                 btb_we;
  logic                 pht_we;

  logic [IDX_BITS-1:0]  hist_ext;
  logic                 gshare_mode;

  // Modes 2 and 3 both select gshare indexing; mode 0 and 1 index bimodally.
  assign gshare_mode = bus.mode[1];

  // Zero-extend the history to index width (HIST_BITS may be narrower than IDX_BITS).
  always_comb begin
    hist_ext                = '0;
    hist_ext[HIST_BITS-1:0] = bhsr_q;
  end

  // Combinational prediction from pre-update state.
  always_comb begin
    lkp_idx     = bus.current_pc[IDX_BITS+1:2];
    lkp_tag     = bus.current_pc[31:IDX_BITS+2];
    lkp_hit     = btb_valid_q[lkp_idx] && (btb_tag_q[lkp_idx] == lkp_tag);
    lkp_pht_idx = gshare_mode ? (lkp_idx ^ hist_ext) : lkp_idx;
    lkp_ctr     = pht_q[lkp_pht_idx];
    lkp_taken   = lkp_hit && (bus.mode != 2'd0) && lkp_ctr[CTR_BITS-1];
  end

  assign bus.pred_taken = lkp_taken;
  assign bus.pc_predict = lkp_taken ? btb_target_q[lkp_idx] : bus.current_pc + 32'd4;

  // Decode the resolved instruction: taken-ness, BTB write enable and the counter step.
  always_comb begin
    upd_idx      = bus.upd_pc[IDX_BITS+1:2];
    upd_tag      = bus.upd_pc[31:IDX_BITS+2];
    upd_hit      = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
    upd_pht_idx  = gshare_mode ? (upd_idx ^ hist_ext) : upd_idx;
    upd_ctr      = pht_q[upd_pht_idx];
    actual_taken = bus.upd_target != (bus.upd_pc + 32'd4);
    // Only taken resolutions allocate/retarget; a hit with a correct prediction is left alone.
    btb_we       = bus.upd_valid && actual_taken && (bus.upd_mispredict || !upd_hit);
    pht_we       = bus.upd_valid && bus.upd_is_cond;

    upd_ctr_next = upd_ctr;
    if (actual_taken) begin
      if (upd_ctr != CtrMax) upd_ctr_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_BITS'(1);
    end
  end

  // Next-state for history and saturating event counters.
  always_comb begin
    bhsr_d = bhsr_q;
    if (pht_we) bhsr_d = (bhsr_q << 1) | HIST_BITS'(actual_taken);

    stat_lookups_d = stat_lookups_q;
    if (bus.lookup_valid && (stat_lookups_q != '1)) stat_lookups_d = stat_lookups_q + 32'd1;

    stat_mispredicts_d = stat_mispredicts_q;
    if (bus.upd_valid && bus.upd_mispredict && (stat_mispredicts_q != '1)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  // BTB storage: cleared on reset, written on taken mispredicts or taken misses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else if (btb_we) begin
      btb_valid_q[upd_idx]  <= 1'b1;
      btb_tag_q[upd_idx]    <= upd_tag;
      btb_target_q[upd_idx] <= bus.upd_target;
    end
  end

  // PHT storage: counters start weakly not-taken, step on conditional resolutions only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pht_q[i] <= CtrWeakNt;
      end
    end else if (pht_we) begin
      pht_q[upd_pht_idx] <= upd_ctr_next;
    end
  end

  // Global history and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bhsr_q             <= '0;
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      bhsr_q             <= bhsr_d;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_lookups     = stat_lookups_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed and randomized checks of branch_predictor_gshare against a behavioural model.
module tb_branch_predictor_gshare;
  localparam int IDX  = 5;
  localparam int HIST = 5;
  localparam int CTR  = 2;
  localparam int D    = 1 << IDX;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_gshare_if bus_if ();

  branch_predictor_gshare #(
    .IDX_BITS (IDX),
    .HIST_BITS(HIST),
    .CTR_BITS (CTR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit          m_valid [D];
  logic [31:0] m_tag   [D];
  logic [31:0] m_tgt   [D];
  int          m_pht   [D];
  int          m_hist;
  logic [31:0] m_sl, m_sm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pht_index(input logic [31:0] pc, input logic [1:0] mode);
    int idx = int'((pc >> 2) % D);
    return (mode >= 2) ? ((idx ^ m_hist) % D) : idx;
  endfunction

  function automatic bit btb_hit(input logic [31:0] pc);
    int idx = int'((pc >> 2) % D);
    return m_valid[idx] && (m_tag[idx] == (pc >> (IDX + 2)));
  endfunction

  task automatic model_predict(input logic [31:0] pc, input logic [1:0] mode,
                               output logic taken, output logic [31:0] npc);
    int idx = int'((pc >> 2) % D);
    taken = btb_hit(pc) && (mode != 0) && (m_pht[pht_index(pc, mode)] >= (1 << (CTR - 1)));
    npc   = taken ? m_tgt[idx] : pc + 32'd4;
  endtask

  // Applies the inputs present at the clock edge to the model.
  task automatic model_update();
    logic [31:0] pc = bus_if.upd_pc;
    bit          act;
    int          idx, pidx;
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_pht[i] = (1 << (CTR - 1)) - 1;
      end
      m_hist = 0; m_sl = '0; m_sm = '0;
      return;
    end
    if (bus_if.lookup_valid && m_sl != 32'hFFFF_FFFF) m_sl++;
    if (!bus_if.upd_valid) return;
    if (bus_if.upd_mispredict && m_sm != 32'hFFFF_FFFF) m_sm++;
    act  = bus_if.upd_target != pc + 32'd4;
    idx  = int'((pc >> 2) % D);
    pidx = pht_index(pc, bus_if.mode);
    if (act && (bus_if.upd_mispredict || !btb_hit(pc))) begin
      m_valid[idx] = 1; m_tag[idx] = pc >> (IDX + 2); m_tgt[idx] = bus_if.upd_target;
    end
    if (bus_if.upd_is_cond) begin
      if (act) m_pht[pidx] = (m_pht[pidx] == (1 << CTR) - 1) ? m_pht[pidx] : m_pht[pidx] + 1;
      else     m_pht[pidx] = (m_pht[pidx] == 0) ? 0 : m_pht[pidx] - 1;
      m_hist = ((m_hist << 1) | int'(act)) % (1 << HIST);
    end
  endtask

  // One cycle: compare outputs for the inputs now applied, then clock and advance the model.
  task automatic tick();
    logic        et;
    logic [31:0] ep;
    #1;
    model_predict(bus_if.current_pc, bus_if.mode, et, ep);
    check("pred_taken", {31'd0, bus_if.pred_taken}, {31'd0, et});
    check("pc_predict", bus_if.pc_predict, ep);
    check("stat_lookups", bus_if.stat_lookups, m_sl);
    check("stat_mispredicts", bus_if.stat_mispredicts, m_sm);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Reset asserted together with an update and lookup_valid to exercise priority.
  task automatic do_reset();
    reset                 = 1'b1;
    bus_if.lookup_valid   = 1'b1;
    bus_if.upd_valid      = 1'b1;
    bus_if.upd_pc         = 32'h100;
    bus_if.upd_target     = 32'h200;
    bus_if.upd_is_cond    = 1'b1;
    bus_if.upd_mispredict = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset            = 1'b0;
    bus_if.upd_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic cond,
                     input logic mis);
    bus_if.upd_valid      = 1'b1;
    bus_if.upd_pc         = pc;
    bus_if.upd_target     = tgt;
    bus_if.upd_is_cond    = cond;
    bus_if.upd_mispredict = mis;
    tick();
    bus_if.upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus_if.current_pc = pc;
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h1000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    reset                 = 1'b0;
    bus_if.mode           = 2'd2;
    bus_if.current_pc     = 32'h100;
    bus_if.lookup_valid   = 1'b1;
    bus_if.upd_valid      = 1'b0;
    bus_if.upd_pc         = '0;
    bus_if.upd_target     = '0;
    bus_if.upd_is_cond    = 1'b0;
    bus_if.upd_mispredict = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    look(32'h100);
    check("rst_pc_predict", bus_if.pc_predict, 32'h104);
    check("rst_pred_taken", {31'd0, bus_if.pred_taken}, 32'd0);
    check("rst_stat_lookups", bus_if.stat_lookups, 32'd0);
    check("rst_stat_mispredicts", bus_if.stat_mispredicts, 32'd0);
    tick();

    // gshare: two taken trainings at the same history (0), flushed back to 0 by 5 not-taken
    bus_if.mode = 2'd2;
    do_reset();
    bus_if.current_pc = 32'h100;
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) upd(32'h10C, 32'h110, 1'b1, 1'b0);
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) upd(32'h10C, 32'h110, 1'b1, 1'b0);
    look(32'h100);
    check("gshare_pc_predict", bus_if.pc_predict, 32'h200);
    check("gshare_stat_mispredicts", bus_if.stat_mispredicts, 32'd2);
    tick();

    // bimodal: saturate taken, drain to 00, BTB target retained
    bus_if.mode = 2'd1;
    do_reset();
    bus_if.current_pc = 32'h100;
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    look(32'h100);
    check("bimodal_trained_pc", bus_if.pc_predict, 32'h200);
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h104, 1'b1, 1'b1);
    look(32'h100);
    check("bimodal_drained_taken", {31'd0, bus_if.pred_taken}, 32'd0);
    check("bimodal_drained_pc", bus_if.pc_predict, 32'h104);
    // Correct-prediction hits never retarget, so 0x200 must come back from the kept entry.
    upd(32'h100, 32'h300, 1'b1, 1'b0);
    upd(32'h100, 32'h300, 1'b1, 1'b0);
    look(32'h100);
    check("btb_retained_pc", bus_if.pc_predict, 32'h200);

    // Aliasing: same index, different tag
    look(32'h180);
    check("alias_pc", bus_if.pc_predict, 32'h184);
    check("alias_taken", {31'd0, bus_if.pred_taken}, 32'd0);
    tick();

    // Mode 0 suppresses, mode 1 restores unchanged
    bus_if.mode = 2'd0;
    look(32'h100);
    check("mode0_taken", {31'd0, bus_if.pred_taken}, 32'd0);
    check("mode0_pc", bus_if.pc_predict, 32'h104);
    tick();
    bus_if.mode = 2'd1;
    look(32'h100);
    check("mode1_back_pc", bus_if.pc_predict, 32'h200);

    // Same-cycle update and lookup
    bus_if.upd_valid      = 1'b1;
    bus_if.upd_pc         = 32'h100;
    bus_if.upd_target     = 32'h240;
    bus_if.upd_is_cond    = 1'b1;
    bus_if.upd_mispredict = 1'b1;
    #1;
    check("same_cycle_old_pc", bus_if.pc_predict, 32'h200);
    tick();
    bus_if.upd_valid = 1'b0;
    look(32'h100);
    check("next_cycle_new_pc", bus_if.pc_predict, 32'h240);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      bus_if.mode           = 2'($urandom_range(0, 3));
      bus_if.current_pc     = rand_pc();
      bus_if.lookup_valid   = 1'($urandom_range(0, 1));
      bus_if.upd_valid      = ($urandom_range(0, 3) != 0);
      bus_if.upd_pc         = rand_pc();
      bus_if.upd_target     = $urandom_range(0, 1) ? bus_if.upd_pc + 32'd4
                                                   : 32'h2000 + 32'($urandom_range(0, 15)) * 4;
      bus_if.upd_is_cond    = ($urandom_range(0, 3) != 0);
      bus_if.upd_mispredict = 1'($urandom_range(0, 1));
      tick();
    end
    bus_if.upd_valid = 1'b0;

    // Counter saturation: preload both counters one below the ceiling
    bus_if.lookup_valid = 1'b0;
    force dut.stat_lookups_q     = 32'hFFFF_FFFE;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.stat_lookups_q;
    release dut.stat_mispredicts_q;
    m_sl = 32'hFFFF_FFFE;
    m_sm = 32'hFFFF_FFFE;
    bus_if.lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) upd(32'h100, 32'h104, 1'b0, 1'b1);
    #1;
    check("sat_stat_lookups", bus_if.stat_lookups, 32'hFFFF_FFFF);
    check("sat_stat_mispredicts", bus_if.stat_mispredicts, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
